rggen_timer_bank: RTL

Parametrised APB register block driving CHANNELS independent reload down-counters, each with a sticky expiry flag, an overrun flag and a maskable interrupt. It generalises the fixed three-register sample block to a configurable channel count and counter width, and adds write-1-to-clear status and internal counting state. It sits on the peripheral APB bus next to the other rggen register blocks and feeds per-channel interrupts to the interrupt controller.

---
 rtl/rggen_timer_bank.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/rggen_timer_bank.sv
// rggen_timer_bank: APB register block with CHANNELS reload down-counters.
// Each channel has CTRL/LOAD/COUNT/STATUS registers, a sticky expiry flag,
// an overrun flag and a level interrupt gated by IRQ_EN.
module rggen_timer_bank #(
  parameter int CHANNELS      = 4,
  parameter int COUNTER_WIDTH = 16,
  parameter int ADDRESS_WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_psel,
  input  logic                     i_penable,
  input  logic [ADDRESS_WIDTH-1:0] i_paddr,
  input  logic                     i_pwrite,
  input  logic [31:0]              i_pwdata,
  input  logic [3:0]               i_pstrb,
  output logic                     o_pready,
  output logic [31:0]              o_prdata,
  output logic                     o_pslverr,
  input  logic [CHANNELS-1:0]      i_tick,
  output logic [CHANNELS-1:0]      o_irq
);

  localparam int unsigned ADDR_LIMIT = CHANNELS * 16;
  localparam int          CHW        = ADDRESS_WIDTH - 4;

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t state_q, state_d;

  logic                     pready_q, pready_d;
  logic [31:0]              prdata_q, prdata_d;
  logic                     pslverr_q, pslverr_d;
  logic                     commit;

  logic                     addr_err;
  logic [1:0]               reg_sel;
  logic [CHANNELS-1:0]      ch_sel;
  logic [31:0]              rd_data;

  logic [CHANNELS-1:0]      en_vec;
  logic [CHANNELS-1:0]      irq_en_vec;
  logic [CHANNELS-1:0]      expired_vec;
  logic [CHANNELS-1:0]      overrun_vec;
  logic [COUNTER_WIDTH-1:0] load_arr  [CHANNELS];
  logic [COUNTER_WIDTH-1:0] count_arr [CHANNELS];

  // Misaligned or out-of-range addresses get an error response and no effect
  assign addr_err = (i_paddr[1:0] != 2'b00) ||
                    ({{(32-ADDRESS_WIDTH){1'b0}}, i_paddr} >= ADDR_LIMIT);
  assign reg_sel  = i_paddr[3:2];

  // Read mux over the decoded channel, sampled by the FSM in the first access cycle
  always_comb begin
    rd_data = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (ch_sel[i]) begin
        case (reg_sel)
          2'd0:    rd_data = {30'b0, irq_en_vec[i], en_vec[i]};
          2'd1:    rd_data = 32'(load_arr[i]);
          2'd2:    rd_data = 32'(count_arr[i]);
          default: rd_data = {30'b0, overrun_vec[i], expired_vec[i]};
        endcase
      end
    end
  end

  // Access FSM state register; reset abandons any transfer in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: setup arms ACCESS, penable moves to RESP, psel loss aborts
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (i_psel && !i_penable) state_d = ACCESS;
      ACCESS: begin
        if (!i_psel) begin
          state_d = IDLE;
        end else if (i_penable) begin
          state_d = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs: response registered out of ACCESS, write commits at the end of RESP
  always_comb begin
    pready_d  = 1'b0;
    prdata_d  = '0;
    pslverr_d = 1'b0;
    commit    = 1'b0;
    case (state_q)
      ACCESS: begin
        if (i_psel && i_penable) begin
          pready_d  = 1'b1;
          pslverr_d = addr_err;
          if (!i_pwrite && !addr_err) prdata_d = rd_data;
        end
      end
      RESP:    commit = i_psel && i_penable && i_pwrite && !addr_err;
      default: ;
    endcase
  end

  // Registered APB response; held for the single pready cycle then cleared
  always_ff @(posedge clk) begin
    if (rst) begin
      pready_q  <= 1'b0;
      prdata_q  <= '0;
      pslverr_q <= 1'b0;
    end else begin
      pready_q  <= pready_d;
      prdata_q  <= prdata_d;
      pslverr_q <= pslverr_d;
    end
  end

  assign o_pready  = pready_q;
  assign o_prdata  = prdata_q;
  assign o_pslverr = pslverr_q;

  for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
    logic                     en_q, en_d;
    logic                     irq_en_q, irq_en_d;
    logic                     expired_q, expired_d;
    logic                     overrun_q, overrun_d;
    logic [COUNTER_WIDTH-1:0] load_q, load_d;
    logic [COUNTER_WIDTH-1:0] count_q, count_d;
    logic [31:0]              load_wide;
    logic                     wr_ctrl, wr_load, wr_stat;
    logic                     en_rise, tick_ok, expire;

    assign ch_sel[gi] = !addr_err && (i_paddr[ADDRESS_WIDTH-1:4] == CHW'(gi));

    assign wr_ctrl = commit && ch_sel[gi] && (reg_sel == 2'd0) && i_pstrb[0];
    assign wr_load = commit && ch_sel[gi] && (reg_sel == 2'd1);
    assign wr_stat = commit && ch_sel[gi] && (reg_sel == 2'd3) && i_pstrb[0];

    // Enabling from idle restarts the count from LOAD instead of consuming a tick
    assign en_rise = wr_ctrl && !en_q && i_pwdata[0];
    assign tick_ok = en_q && i_tick[gi];
    assign expire  = tick_ok && (count_q == '0);

    // Byte-lane merge of LOAD writes; lanes above the counter width fall away
    always_comb begin
      load_wide = 32'(load_q);
      for (int b = 0; b < 4; b++) begin
        if (i_pstrb[b]) load_wide[8*b +: 8] = i_pwdata[8*b +: 8];
      end
    end

    // Per-channel next state: counting, reload, and sticky flags where set beats clear
    always_comb begin
      en_d      = wr_ctrl ? i_pwdata[0] : en_q;
      irq_en_d  = wr_ctrl ? i_pwdata[1] : irq_en_q;
      load_d    = wr_load ? load_wide[COUNTER_WIDTH-1:0] : load_q;
      count_d   = count_q;
      if (en_rise) begin
        count_d = load_q;
      end else if (tick_ok) begin
        count_d = expire ? load_q : count_q - COUNTER_WIDTH'(1);
      end
      expired_d = expire || (expired_q && !(wr_stat && i_pwdata[0]));
      overrun_d = (expire && expired_q) || (overrun_q && !(wr_stat && i_pwdata[1]));
    end

    // Per-channel register state
    always_ff @(posedge clk) begin
      if (rst) begin
        en_q      <= 1'b0;
        irq_en_q  <= 1'b0;
        expired_q <= 1'b0;
        overrun_q <= 1'b0;
        load_q    <= '0;
        count_q   <= '0;
      end else begin
        en_q      <= en_d;
        irq_en_q  <= irq_en_d;
        expired_q <= expired_d;
        overrun_q <= overrun_d;
        load_q    <= load_d;
        count_q   <= count_d;
      end
    end

    assign en_vec[gi]      = en_q;
    assign irq_en_vec[gi]  = irq_en_q;
    assign expired_vec[gi] = expired_q;
    assign overrun_vec[gi] = overrun_q;
    assign load_arr[gi]    = load_q;
    assign count_arr[gi]   = count_q;
    assign o_irq[gi]       = expired_q && irq_en_q;
  end

endmodule
